// File: rtl/dec_stage.sv
// RiSC-16 instruction-decode stage.
// Splits the IF/ID instruction into fields, drives register-file read addresses,
// resolves operands by forwarding from EX/MEM/WB, detects load-use hazards and
// registers the ID/EX pipeline register.
module dec_stage #(
  parameter int unsigned p_WORD_LEN     = 16,
  parameter int unsigned p_REG_ADDR_LEN = 3,
  parameter int unsigned p_PC_LEN       = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [p_WORD_LEN-1:0]     i_instr,
  input  logic [p_PC_LEN-1:0]       i_pc,
  input  logic                      i_flush,
  output logic                      o_stall,
  output logic [p_REG_ADDR_LEN-1:0] o_src1,
  output logic [p_REG_ADDR_LEN-1:0] o_src2,
  input  logic [p_WORD_LEN-1:0]     i_src1_data,
  input  logic [p_WORD_LEN-1:0]     i_src2_data,
  input  logic [p_WORD_LEN-1:0]     i_ex_result,
  input  logic                      i_mem_wr_en,
  input  logic [p_REG_ADDR_LEN-1:0] i_mem_tgt,
  input  logic [p_WORD_LEN-1:0]     i_mem_data,
  input  logic                      i_wb_wr_en,
  input  logic [p_REG_ADDR_LEN-1:0] i_wb_tgt,
  input  logic [p_WORD_LEN-1:0]     i_wb_data,
  output logic                      o_valid,
  output logic [2:0]                o_op,
  output logic [p_REG_ADDR_LEN-1:0] o_tgt,
  output logic                      o_wr_en,
  output logic [p_WORD_LEN-1:0]     o_opA,
  output logic [p_WORD_LEN-1:0]     o_opB,
  output logic [p_WORD_LEN-1:0]     o_imm,
  output logic [p_PC_LEN-1:0]       o_pc
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam int unsigned IMM7_LEN  = 7;
  localparam int unsigned IMM10_LEN = 10;

  logic [2:0]                op;
  logic [p_REG_ADDR_LEN-1:0] ra;
  logic [p_REG_ADDR_LEN-1:0] rb;
  logic [p_REG_ADDR_LEN-1:0] rc;
  logic [p_WORD_LEN-1:0]     imm_sext7;
  logic [p_WORD_LEN-1:0]     imm_lui;

  logic [p_REG_ADDR_LEN-1:0] src1;
  logic [p_REG_ADDR_LEN-1:0] src2;
  logic [p_WORD_LEN-1:0]     dec_imm;
  logic                      dec_wr_en;
  logic [p_WORD_LEN-1:0]     opa_fwd;
  logic [p_WORD_LEN-1:0]     opb_fwd;
  logic                      ex_fwd_en;
  logic                      src1_hit;
  logic                      src2_hit;

  // Instruction field extraction
  assign op        = i_instr[15:13];
  assign ra        = p_REG_ADDR_LEN'(i_instr[12:10]);
  assign rb        = p_REG_ADDR_LEN'(i_instr[9:7]);
  assign rc        = p_REG_ADDR_LEN'(i_instr[2:0]);
  assign imm_sext7 = {{(p_WORD_LEN-IMM7_LEN){i_instr[6]}}, i_instr[6:0]};
  assign imm_lui   = {i_instr[9:0], {(p_WORD_LEN-IMM10_LEN){1'b0}}};

  // Operand-source select, immediate expansion and write-enable decode
  always_comb begin
    src1      = '0;
    src2      = '0;
    dec_imm   = '0;
    dec_wr_en = 1'b0;
    case (op)
      OP_ADD, OP_NAND: begin
        src1      = rb;
        src2      = rc;
        dec_wr_en = (ra != '0);
      end
      OP_ADDI: begin
        src1      = rb;
        dec_imm   = imm_sext7;
        dec_wr_en = (ra != '0);
      end
      OP_LUI: begin
        dec_imm   = imm_lui;
        dec_wr_en = (ra != '0);
      end
      OP_SW: begin
        src1    = rb;
        src2    = ra;
        dec_imm = imm_sext7;
      end
      OP_LW: begin
        src1      = rb;
        dec_imm   = imm_sext7;
        dec_wr_en = (ra != '0);
      end
      OP_BEQ: begin
        src1    = ra;
        src2    = rb;
        dec_imm = imm_sext7;
      end
      OP_JALR: begin
        src1      = rb;
        dec_wr_en = (ra != '0);
      end
      default: begin
        src1 = '0;
      end
    endcase
  end

  assign o_src1 = src1;
  assign o_src2 = src2;

  // A load in EX has no result yet, so it must not be forwarded from EX
  assign ex_fwd_en = o_valid & o_wr_en & (o_op != OP_LW);

  // Operand A forwarding: r0, then EX, MEM, WB, register file
  always_comb begin
    opa_fwd = i_src1_data;
    if (src1 == '0) begin
      opa_fwd = '0;
    end else if (ex_fwd_en && (o_tgt == src1)) begin
      opa_fwd = i_ex_result;
    end else if (i_mem_wr_en && (i_mem_tgt == src1)) begin
      opa_fwd = i_mem_data;
    end else if (i_wb_wr_en && (i_wb_tgt == src1)) begin
      opa_fwd = i_wb_data;
    end
  end

  // Operand B forwarding: same priority as operand A
  always_comb begin
    opb_fwd = i_src2_data;
    if (src2 == '0) begin
      opb_fwd = '0;
    end else if (ex_fwd_en && (o_tgt == src2)) begin
      opb_fwd = i_ex_result;
    end else if (i_mem_wr_en && (i_mem_tgt == src2)) begin
      opb_fwd = i_mem_data;
    end else if (i_wb_wr_en && (i_wb_tgt == src2)) begin
      opb_fwd = i_wb_data;
    end
  end

  // Load-use hazard: a used nonzero source matches the load target in EX
  assign src1_hit = (src1 != '0) && (src1 == o_tgt);
  assign src2_hit = (src2 != '0) && (src2 == o_tgt);
  assign o_stall  = i_valid & o_valid & (o_op == OP_LW) & o_wr_en &
                    (src1_hit | src2_hit) & ~i_flush;

  // ID/EX pipeline register: reset, flush/stall bubble, or load decoded fields
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_op    <= '0;
      o_tgt   <= '0;
      o_wr_en <= 1'b0;
      o_opA   <= '0;
      o_opB   <= '0;
      o_imm   <= '0;
      o_pc    <= '0;
    end else if (i_flush || o_stall) begin
      o_valid <= 1'b0;
      o_wr_en <= 1'b0;
    end else begin
      o_valid <= i_valid;
      o_op    <= op;
      o_tgt   <= ra;
      o_wr_en <= dec_wr_en & i_valid;
      o_opA   <= opa_fwd;
      o_opB   <= opb_fwd;
      o_imm   <= dec_imm;
      o_pc    <= i_pc;
    end
  end

endmodule
